// File: rtl/cosi_pwr_pkg.sv
// Shared types and default timing constants for the COSI power-board relay controller.
package cosi_pwr_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TIMING   = 2'd1,
    WAIT_REL = 2'd2
  } ch_state_t;

  localparam int unsigned DEF_DB_CYC   = 2048;
  localparam int unsigned DEF_LONG_CYC = 2**24;

endpackage

// File: rtl/relay_btn_debounce.sv
// Single-button front end: 2-FF synchroniser, counter debounce, rising-edge detect.
module relay_btn_debounce
  import cosi_pwr_pkg::*;
#(
  parameter int unsigned DB_CYC = DEF_DB_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  output logic dbState,
  output logic dbRise
);

  localparam int unsigned CNT_W = $clog2(DB_CYC);

  logic             sync1;
  logic             sync2;
  logic             dbQ;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then flip the debounced state only after DB_CYC consecutive disagreeing cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      dbState <= 1'b0;
      dbQ     <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1 <= btnRaw;
      sync2 <= sync1;
      dbQ   <= dbState;
      if (sync2 != dbState) begin
        if (cnt == CNT_W'(DB_CYC - 1)) begin
          dbState <= ~dbState;
          cnt     <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // One-cycle pulse on the debounced press edge.
  assign dbRise = dbState & ~dbQ;

endmodule

// File: rtl/relay_ctrl_multi.sv
// N-channel push-button relay controller: short press turns a relay on, a long hold turns it off.
// Channels flagged in DEP_MASK are interlocked on channel 0.
// Optional build macro CASCADE_OFF_EN: switching channel 0 off also clears its dependent channels.
module relay_ctrl_multi
  import cosi_pwr_pkg::*;
#(
  parameter int unsigned        N_CH     = 2,
  parameter int unsigned        DB_CYC   = DEF_DB_CYC,
  parameter int unsigned        LONG_CYC = DEF_LONG_CYC,
  parameter logic [N_CH-1:0]    DEP_MASK = N_CH'(2'b10)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] relay_o,
  output logic [N_CH-1:0] led_o
);

  localparam int unsigned TMR_W = $clog2(LONG_CYC);

  logic [N_CH-1:0] dbState;
  logic [N_CH-1:0] dbRise;
  logic [N_CH-1:0] onQ;
  logic [N_CH-1:0] termC;

`ifdef CASCADE_OFF_EN
  logic masterFallC;

  // Channel 0 is about to switch off on the coming edge.
  assign masterFallC = onQ[0] & termC[0];
`endif

  for (genvar g = 0; g < N_CH; g++) begin : gCh
    ch_state_t        chState;
    logic [TMR_W-1:0] tmr;
    logic             onBit;

`ifdef CASCADE_OFF_EN
    localparam bit IS_DEP = (g != 0) && DEP_MASK[g];
`endif

    relay_btn_debounce #(
      .DB_CYC (DB_CYC)
    ) uDb (
      .clk     (clk),
      .rst     (rst),
      .btnRaw  (btn_i[g]),
      .dbState (dbState[g]),
      .dbRise  (dbRise[g])
    );

    // Long-press terminal: still held on the last timing cycle (a release on that cycle wins).
    assign termC[g] = (chState == TIMING) & dbState[g] & (tmr == TMR_W'(LONG_CYC - 1));

    // Per-channel press FSM with its own hold timer.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        chState <= IDLE;
        tmr     <= '0;
        onBit   <= 1'b0;
      end else begin
`ifdef CASCADE_OFF_EN
        if (IS_DEP && masterFallC) begin
          onBit   <= 1'b0;
          chState <= dbState[g] ? WAIT_REL : IDLE;
        end else begin
`endif
          case (chState)
            IDLE: begin
              if (dbRise[g]) begin
                onBit   <= 1'b1;
                tmr     <= '0;
                chState <= TIMING;
              end
            end
            TIMING: begin
              if (!dbState[g]) begin
                chState <= IDLE;
              end else if (termC[g]) begin
                onBit   <= 1'b0;
                chState <= WAIT_REL;
              end else begin
                tmr <= tmr + TMR_W'(1);
              end
            end
            WAIT_REL: begin
              if (!dbState[g]) begin
                chState <= IDLE;
              end
            end
            default: chState <= IDLE;
          endcase
`ifdef CASCADE_OFF_EN
        end
`endif
      end
    end

    assign onQ[g]     = onBit;
    assign relay_o[g] = onBit & (DEP_MASK[g] ? onQ[0] : 1'b1);
  end

  assign led_o = onQ;

endmodule

// File: tb/tb_relay_ctrl_multi.sv
// Scoreboard bench for relay_ctrl_multi (N_CH=2, DB_CYC=4, LONG_CYC=16, DEP_MASK=2'b10).
module tb_relay_ctrl_multi;

`ifdef CASCADE_OFF_EN
  localparam bit CAS_EN = 1'b1;
`else
  localparam bit CAS_EN = 1'b0;
`endif

  typedef struct {
    string      tag;
    bit         isRelay;
    logic [1:0] mask;
    logic [1:0] exp;
    int         due;
  } sbEntry_t;

  logic       clk;
  logic       rst;
  logic [1:0] btn;
  logic [1:0] relay;
  logic [1:0] led;

  int cyc = 0;
  int errCnt = 0;
  int chkCnt = 0;
  sbEntry_t sbQ[$];

  relay_ctrl_multi #(
    .N_CH     (2),
    .DB_CYC   (4),
    .LONG_CYC (16),
    .DEP_MASK (2'b10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn),
    .relay_o (relay),
    .led_o   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expectAt(input string tag, input bit isRelay, input logic [1:0] mask,
                          input logic [1:0] exp, input int dly);
    sbEntry_t e;
    e.tag     = tag;
    e.isRelay = isRelay;
    e.mask    = mask;
    e.exp     = exp;
    e.due     = cyc + dly;
    sbQ.push_back(e);
  endtask

  task automatic waitCyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int ch, input int hold);
    btn[ch] = 1'b1;
    waitCyc(hold);
    btn[ch] = 1'b0;
  endtask

  // Compare every scoreboard entry that falls due this cycle.
  always @(negedge clk) begin
    for (int i = sbQ.size() - 1; i >= 0; i--) begin
      if (sbQ[i].due == cyc) begin
        logic [1:0] got;
        got = sbQ[i].isRelay ? relay : led;
        checkVal(sbQ[i].tag, 32'(got & sbQ[i].mask), 32'(sbQ[i].exp & sbQ[i].mask));
        sbQ.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    btn = 2'b11;
    waitCyc(1);

    // Buttons held through reset: outputs stay low, then both switch on after release.
    for (int d = 1; d <= 5; d++) begin
      expectAt("rstLed", 1'b0, 2'b11, 2'b00, d);
      expectAt("rstRly", 1'b1, 2'b11, 2'b00, d);
    end
    waitCyc(5);
    rst = 1'b0;
    expectAt("relLed6", 1'b0, 2'b11, 2'b00, 6);
    expectAt("relLed7", 1'b0, 2'b11, 2'b11, 7);
    expectAt("relRly7", 1'b1, 2'b11, 2'b11, 7);
    waitCyc(8);
    btn = 2'b00;
    expectAt("bothStay", 1'b0, 2'b11, 2'b11, 12);
    waitCyc(14);

    // Clean reset to start from all-off.
    rst = 1'b1;
    expectAt("rst2Led", 1'b0, 2'b11, 2'b00, 1);
    expectAt("rst2Rly", 1'b1, 2'b11, 2'b00, 1);
    waitCyc(2);
    rst = 1'b0;
    waitCyc(2);

    // Bounce shorter than the debounce window is ignored.
    for (int k = 0; k < 20; k++) begin
      btn[0] = ((k / 2) % 2) == 0;
      expectAt("bounce", 1'b0, 2'b01, 2'b00, 1);
      waitCyc(1);
    end
    btn = 2'b00;
    expectAt("bounceEnd", 1'b0, 2'b11, 2'b00, 8);
    waitCyc(10);

    // Short press on ch0.
    expectAt("shortLed6", 1'b0, 2'b01, 2'b00, 6);
    expectAt("shortLed7", 1'b0, 2'b11, 2'b01, 7);
    expectAt("shortRly7", 1'b1, 2'b11, 2'b01, 7);
    expectAt("shortHeld", 1'b0, 2'b01, 2'b01, 25);
    press(0, 10);
    waitCyc(20);

    // Long press on ch0 (already on): off 16 cycles after the timed press starts, ignored while held.
    expectAt("longLed22", 1'b0, 2'b01, 2'b01, 22);
    expectAt("longLed23", 1'b0, 2'b01, 2'b00, 23);
    expectAt("longHeld",  1'b0, 2'b01, 2'b00, 29);
    expectAt("longRel",   1'b0, 2'b01, 2'b00, 40);
    press(0, 30);
    waitCyc(14);

    // Interlock: ch1 stored on but gated while ch0 is off.
    expectAt("ilLed", 1'b0, 2'b11, 2'b10, 7);
    expectAt("ilRly", 1'b1, 2'b11, 2'b00, 7);
    press(1, 10);
    waitCyc(20);
    expectAt("ilBothLed", 1'b0, 2'b11, 2'b11, 7);
    expectAt("ilBothRly", 1'b1, 2'b11, 2'b11, 7);
    press(0, 10);
    waitCyc(20);

    // Release on the terminal-count cycle keeps the relay on.
    expectAt("edgeRelLed", 1'b0, 2'b11, 2'b11, 30);
    expectAt("edgeRelRly", 1'b1, 2'b11, 2'b11, 30);
    press(0, 16);
    waitCyc(20);

    // Master long press with a dependent on.
    expectAt("casLed22", 1'b0, 2'b11, 2'b11, 22);
    expectAt("casLed23", 1'b0, 2'b11, CAS_EN ? 2'b00 : 2'b10, 23);
    expectAt("casRly23", 1'b1, 2'b11, 2'b00, 23);
    press(0, 30);
    waitCyc(14);

    // Master back on: dependent follows only if it kept its stored state.
    expectAt("reOnLed", 1'b0, 2'b11, CAS_EN ? 2'b01 : 2'b11, 7);
    expectAt("reOnRly", 1'b1, 2'b11, CAS_EN ? 2'b01 : 2'b11, 7);
    press(0, 10);
    waitCyc(20);

    // Reset in the middle of a press clears everything at once.
    btn[0] = 1'b1;
    waitCyc(3);
    rst = 1'b1;
    expectAt("midRstLed", 1'b0, 2'b11, 2'b00, 1);
    expectAt("midRstRly", 1'b1, 2'b11, 2'b00, 1);
    waitCyc(2);
    btn = 2'b00;
    rst = 1'b0;
    expectAt("postRstLed", 1'b0, 2'b11, 2'b00, 10);
    waitCyc(12);

    checkVal("sbDrain", 32'(sbQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
